// File: rtl/paddle_mover.sv
// Two-axis paddle position controller: synchronised active-low buttons, per-axis
// press/hold/auto-repeat stepping with clamping. Define PADDLE_ACCEL_EN to add the FAST state.
module paddle_mover #(
    parameter int unsigned POS_W       = 11,
    parameter int unsigned H_MIN       = 10,
    parameter int unsigned H_MAX       = 530,
    parameter int unsigned V_MIN       = 10,
    parameter int unsigned V_MAX       = 200,
    parameter int unsigned H_INIT      = 325,
    parameter int unsigned V_INIT      = 10,
    parameter int unsigned STEP        = 10,
    parameter int unsigned TICK_DIV    = 1,
    parameter int unsigned REPEAT_DLY  = 3,
    parameter int unsigned ACCEL_TICKS = 8
) (
    input  logic             clk_5,
    input  logic             rst,
    input  logic             l_btn,
    input  logic             r_btn,
    input  logic             d_btn,
    input  logic             u_btn,
    output logic [POS_W-1:0] h_pos,
    output logic [POS_W-1:0] v_pos,
    output logic             moving,
    output logic             h_edge,
    output logic             v_edge
);

    localparam int unsigned EXT_W  = POS_W + 1;
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HOLD_W = (REPEAT_DLY > 1) ? $clog2(REPEAT_DLY) : 1;
`ifdef PADDLE_ACCEL_EN
    localparam int unsigned REP_W  = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
`endif

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;
`ifdef PADDLE_ACCEL_EN
    localparam logic [1:0] ST_FAST   = 2'd3;
`endif

    // Button bit order: {u, d, r, l}; bit 2*axis is increment, bit 2*axis+1 is decrement.
    logic [3:0]        r_sync1;
    logic [3:0]        r_sync2;
    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;
    logic [1:0]        w_busy;
    logic [1:0]        w_edge;
    logic [POS_W-1:0]  w_pos [2];
    logic              r_moving;

    always_ff @(posedge clk_5) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= {u_btn, d_btn, r_btn, l_btn};
            r_sync2 <= r_sync1;
        end
    end

    assign w_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk_5) begin
        if (rst || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_axis
        localparam int unsigned AX_MIN  = (g == 0) ? H_MIN : V_MIN;
        localparam int unsigned AX_MAX  = (g == 0) ? H_MAX : V_MAX;
        localparam int unsigned AX_INIT = (g == 0) ? H_INIT : V_INIT;
        localparam logic        AX_EDGE_INIT = (AX_INIT == AX_MIN) || (AX_INIT == AX_MAX);

        logic [1:0]        r_state;
        logic [1:0]        w_state_d;
        logic              r_neg;
        logic              w_neg_d;
        logic [HOLD_W-1:0] r_hold_cnt;
        logic [HOLD_W-1:0] w_hold_cnt_d;
        logic [POS_W-1:0]  r_pos;
        logic [POS_W-1:0]  w_pos_d;
        logic              r_edge;
        logic              w_inc;
        logic              w_dec;
        logic              w_step;
        logic [EXT_W-1:0]  w_ext;
        logic [EXT_W-1:0]  w_s;
`ifdef PADDLE_ACCEL_EN
        logic [REP_W-1:0]  r_rep_cnt;
        logic [REP_W-1:0]  w_rep_cnt_d;
        logic              w_double;
`endif

        assign w_inc = ~r_sync2[2*g];
        assign w_dec = ~r_sync2[2*g+1];

        always_comb begin
            w_state_d    = r_state;
            w_neg_d      = r_neg;
            w_hold_cnt_d = r_hold_cnt;
            w_step       = 1'b0;
`ifdef PADDLE_ACCEL_EN
            w_rep_cnt_d  = r_rep_cnt;
            w_double     = 1'b0;
`endif
            if (w_inc == w_dec) begin
                // Both or neither pressed counts as released.
                w_state_d    = ST_IDLE;
                w_hold_cnt_d = '0;
`ifdef PADDLE_ACCEL_EN
                w_rep_cnt_d  = '0;
`endif
            end else if (r_state == ST_IDLE || w_dec != r_neg) begin
                // Fresh press or reversal: immediate step, then the hold delay starts over.
                w_state_d    = ST_HOLD;
                w_neg_d      = w_dec;
                w_hold_cnt_d = '0;
                w_step       = 1'b1;
`ifdef PADDLE_ACCEL_EN
                w_rep_cnt_d  = '0;
`endif
            end else if (w_tick) begin
                case (r_state)
                    ST_HOLD: begin
                        if (r_hold_cnt == HOLD_W'(REPEAT_DLY - 1)) begin
                            w_state_d    = ST_REPEAT;
                            w_hold_cnt_d = '0;
                        end else begin
                            w_hold_cnt_d = r_hold_cnt + HOLD_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        w_step = 1'b1;
`ifdef PADDLE_ACCEL_EN
                        if (r_rep_cnt == REP_W'(ACCEL_TICKS - 1)) begin
                            w_state_d   = ST_FAST;
                            w_rep_cnt_d = '0;
                        end else begin
                            w_rep_cnt_d = r_rep_cnt + REP_W'(1);
                        end
`endif
                    end
`ifdef PADDLE_ACCEL_EN
                    ST_FAST: begin
                        w_step   = 1'b1;
                        w_double = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end

`ifdef PADDLE_ACCEL_EN
        assign w_s = w_double ? EXT_W'(2 * STEP) : EXT_W'(STEP);
`else
        assign w_s = EXT_W'(STEP);
`endif
        assign w_ext = {1'b0, r_pos};

        // One extra bit keeps pos-s and pos+s from wrapping before the clamp compare.
        always_comb begin
            w_pos_d = r_pos;
            if (w_step) begin
                if (w_neg_d) begin
                    if (w_ext < EXT_W'(AX_MIN) + w_s) begin
                        w_pos_d = POS_W'(AX_MIN);
                    end else begin
                        w_pos_d = POS_W'(w_ext - w_s);
                    end
                end else begin
                    if (w_ext + w_s > EXT_W'(AX_MAX)) begin
                        w_pos_d = POS_W'(AX_MAX);
                    end else begin
                        w_pos_d = POS_W'(w_ext + w_s);
                    end
                end
            end
        end

        always_ff @(posedge clk_5) begin
            if (rst) begin
                r_state    <= ST_IDLE;
                r_neg      <= 1'b0;
                r_hold_cnt <= '0;
                r_pos      <= POS_W'(AX_INIT);
                r_edge     <= AX_EDGE_INIT;
`ifdef PADDLE_ACCEL_EN
                r_rep_cnt  <= '0;
`endif
            end else begin
                r_state    <= w_state_d;
                r_neg      <= w_neg_d;
                r_hold_cnt <= w_hold_cnt_d;
                r_pos      <= w_pos_d;
                r_edge     <= (r_pos == POS_W'(AX_MIN)) || (r_pos == POS_W'(AX_MAX));
`ifdef PADDLE_ACCEL_EN
                r_rep_cnt  <= w_rep_cnt_d;
`endif
            end
        end

        assign w_busy[g] = (r_state != ST_IDLE);
        assign w_edge[g] = r_edge;
        assign w_pos[g]  = r_pos;
    end

    always_ff @(posedge clk_5) begin
        if (rst) begin
            r_moving <= 1'b0;
        end else begin
            r_moving <= |w_busy;
        end
    end

    assign h_pos  = w_pos[0];
    assign v_pos  = w_pos[1];
    assign h_edge = w_edge[0];
    assign v_edge = w_edge[1];
    assign moving = r_moving;

endmodule
